// File: rtl/alu_seq.sv
// alu_seq -- multi-byte operation sequencer for an 8-bit combinational ALU.
//
// A BYTES-wide request (op, A, B, carry-in) is accepted in IDLE, driven
// through the external ALU one byte per cycle in BUSY (carry chained through
// a register), and the assembled result plus flags is presented in DONE until
// the consumer takes it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake; req_op/req_a/req_b/req_ci payload
//   rsp_valid/rsp_ready      response handshake; rsp_y/rsp_n/rsp_v/rsp_z/rsp_c/rsp_err
//   alu_ctrl/ai/bi/ci/daa    drive to the external ALU (all 0 outside BUSY)
//   alu_y/alu_co             combinational result from the external ALU
//   dbg_state                current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid keeps its payload stable; the response
// side holds rsp_valid and every rsp_* field stable until rsp_ready is seen.

module alu_seq #(
   parameter int BYTES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [2:0]           req_op,
   input  logic [8*BYTES-1:0]   req_a,
   input  logic [8*BYTES-1:0]   req_b,
   input  logic                 req_ci,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [8*BYTES-1:0]   rsp_y,
   output logic                 rsp_n,
   output logic                 rsp_v,
   output logic                 rsp_z,
   output logic                 rsp_c,
   output logic                 rsp_err,
   output logic [2:0]           alu_ctrl,
   output logic [7:0]           alu_ai,
   output logic [7:0]           alu_bi,
   output logic                 alu_ci,
   output logic                 alu_daa,
   input  logic [7:0]           alu_y,
   input  logic                 alu_co,
   output logic [1:0]           dbg_state
);

   localparam int W = 8 * BYTES;

   localparam logic [2:0] OP_SUM = 3'd0;
   localparam logic [2:0] OP_SR  = 3'd4;
   localparam logic [2:0] LAST   = 3'(BYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state, state_nx;
   logic [2:0]     cnt;
   logic [2:0]     op_q;
   logic [W-1:0]   a_q, b_q, y_q;
   logic           ci_q, carry_q;

   logic           legal, is_sum, is_sr;
   logic [2:0]     k;          // byte lane handled this BUSY cycle
   logic [7:0]     a_byte, b_byte;

   assign legal  = (op_q <= OP_SR);
   assign is_sum = (op_q == OP_SUM);
   assign is_sr  = (op_q == OP_SR);

   // SR walks from the most significant byte down so each byte's shifted-out
   // LSB becomes the MSB of the next lower byte.
   assign k = is_sr ? (LAST - cnt) : cnt;

   always_comb begin
      a_byte = 8'h00;
      b_byte = 8'h00;
      for (int i = 0; i < BYTES; i++) begin
         if (k == 3'(i)) begin
            a_byte = a_q[8*i +: 8];
            b_byte = b_q[8*i +: 8];
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid)       state_nx = BUSY;
         BUSY:    if (cnt == LAST)     state_nx = DONE;
         DONE:    if (rsp_ready)       state_nx = IDLE;
         default:                      state_nx = IDLE;
      endcase
   end

   // Datapath registers: request latch, byte counter, result and carry capture
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ci_q    <= 1'b0;
         y_q     <= '0;
         carry_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  a_q     <= req_a;
                  b_q     <= req_b;
                  ci_q    <= req_ci;
                  cnt     <= '0;
                  y_q     <= '0;
                  carry_q <= 1'b0;
               end
            end
            BUSY: begin
               cnt <= cnt + 3'd1;
               // Illegal ops leave Y at zero so the response reads 0.
               if (legal) begin
                  for (int i = 0; i < BYTES; i++) begin
                     if (k == 3'(i)) y_q[8*i +: 8] <= alu_y;
                  end
                  carry_q <= alu_co;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_y     = '0;
      rsp_n     = 1'b0;
      rsp_v     = 1'b0;
      rsp_z     = 1'b0;
      rsp_c     = 1'b0;
      rsp_err   = 1'b0;
      alu_ctrl  = 3'd0;
      alu_ai    = 8'h00;
      alu_bi    = 8'h00;
      alu_ci    = 1'b0;
      alu_daa   = 1'b0;

      case (state)
         IDLE: req_ready = !rst;
         BUSY: begin
            if (legal) begin
               alu_ctrl = op_q;
               alu_ai   = a_byte;
               alu_bi   = is_sr ? 8'h00 : b_byte;
               // Carry chains only through SUM and SR; logic ops see 0.
               if (is_sum || is_sr) alu_ci = (cnt == 3'd0) ? ci_q : carry_q;
            end
         end
         DONE: begin
            rsp_valid = 1'b1;
            if (legal) begin
               rsp_y = y_q;
               rsp_n = y_q[W-1];
               rsp_z = (y_q == '0);
               rsp_v = is_sum && (a_q[W-1] == b_q[W-1]) && (y_q[W-1] != a_q[W-1]);
               rsp_c = (is_sum || is_sr) ? carry_q : ci_q;
            end else begin
               rsp_err = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign dbg_state = state;

endmodule
